bno055_op_arbiter: RTL and testbench
====================================

// Module: bno055_op_arbiter
// PURPOSE
//   Shares the single bno055_read_write transaction engine among N_REQ requesters
//   (e.g. mode config writer, Euler reader, calib-status poller). Grants one
//   READ/WRITE op at a time round-robin, pulses the engine opcode, waits for done
//   or timeout, returns read data/status to the owner. Sits between the requester
//   FSMs in bno055_top and the engine.
// PARAMETERS
//   N_REQ          3       number of requesters; legal range 2..8
//   TIMEOUT_CYCLES 250000  max cycles in WAIT before abort (10 ms @ 25 MHz)
//   GAP_CYCLES     16      idle cycles forced after each response; 0 = none
// PORTS
//   i_clk         in   1        system clock
//   i_rst_n       in   1        asynchronous, active-low reset
//   i_req_valid   in   N_REQ    request k pending; held until o_req_ready[k]
//   i_req_opcode  in   2*N_REQ  req k op at [2k+1:2k]: 1=READ, 2=WRITE
//   i_req_addr    in   8*N_REQ  req k register address at [8k+7:8k]
//   i_req_wdata   in   8*N_REQ  req k write data at [8k+7:8k]
//   o_req_ready   out  N_REQ    one-hot 1-cycle accept pulse
//   o_rsp_valid   out  N_REQ    one-hot 1-cycle response pulse to owner
//   o_rsp_data    out  8        read data; valid with o_rsp_valid
//   o_rsp_err     out  1        1 = timeout or illegal opcode; valid with o_rsp_valid
//   o_opcode      out  2        to engine: 0=STOP, 1=READ, 2=WRITE
//   o_reg_addr    out  8        to engine register address
//   o_tx_data     out  8        to engine write data
//   i_reg_data    in   8        engine read data
//   i_done        in   1        engine op-complete pulse
//   o_busy        out  1        1 in any state other than IDLE
//   o_grant_id    out  3        index of current/last owner
// BEHAVIOUR
//   - Reset (async, i_rst_n=0): state IDLE; every output 0; rr pointer = N_REQ-1
//     so requester 0 wins first. All outputs registered.
//   - Requester k must hold valid/opcode/addr/wdata stable until it sees o_req_ready[k];
//     it may re-assert valid at earliest the cycle after ready.
//   - IDLE: if any i_req_valid, pick first set bit searching from ptr+1 mod N_REQ,
//     latch its fields, ptr<=k, o_grant_id<=k; next state ISSUE (legal op) or RESP
//     (illegal op 0/3: no engine op, err=1, data 8'h00).
//   - ISSUE (1 cycle): o_req_ready[k]=1, o_opcode=latched op, o_reg_addr/o_tx_data
//     valid; timeout counter cleared -> WAIT. Engine sees exactly one opcode cycle.
//   - WAIT: o_opcode=0; addr/data held. i_done -> capture i_reg_data (8'h00 for
//     WRITE), err=0 -> RESP. Counter reaching TIMEOUT_CYCLES-1 without done -> data
//     8'h00, err=1 -> RESP. done and timeout same cycle: done wins.
//   - RESP (1 cycle): o_rsp_valid[k]=1 with data/err -> GAP, or IDLE if GAP_CYCLES=0.
//     Illegal-op path also pulses o_req_ready[k] in this cycle.
//   - GAP: count GAP_CYCLES cycles, o_busy=1 -> IDLE.
//   - Latency: valid in IDLE at cycle T -> ready+opcode at T+1; rsp_valid 1 cycle
//     after done. i_done outside WAIT ignored. Requests arriving while busy wait.
//   - No requester starves: after k is served, every other pending requester is served
//     before k again.
//   - Reset mid-op aborts immediately, no response issued; the engine has its own reset.
// TESTING
//   - Single READ: req0 valid, op=1, addr=8'h1C; engine done 40 cycles after opcode
//     with data 8'h5A -> ready0 pulse 1 cycle, o_opcode=1 for 1 cycle, rsp_valid0,
//     data 8'h5A, err=0.
//   - Round-robin: req0,1,2 all valid continuously -> grant order 0,1,2,0,1,2; no
//     overlapping opcode pulses; o_grant_id tracks.
//   - Timeout: TIMEOUT_CYCLES=100, engine never done -> rsp_valid at 100 cycles after
//     ISSUE, err=1, data 8'h00; late i_done afterward ignored.
//   - Illegal op: req1 op=0 -> ready1 and rsp_valid1 same cycle, err=1, o_opcode
//     stays 0.
//   - Collision: i_done on same cycle as timeout expiry -> err=0, data captured.
//   - Reset in WAIT: i_rst_n low -> all outputs 0 immediately; after release req1 and
//     req0 both valid -> req0 granted first.

Source files
------------

// File: rtl/bno055_op_arbiter.sv
// Round-robin arbiter that shares one bno055_read_write engine among N_REQ requesters.
// Each grant issues one READ/WRITE opcode pulse, waits for done or timeout, then returns data/status.
module bno055_op_arbiter #(
   parameter int N_REQ          = 3,
   parameter int TIMEOUT_CYCLES = 250000,
   parameter int GAP_CYCLES     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N_REQ-1:0]     i_req_valid,
   input  logic [2*N_REQ-1:0]   i_req_opcode,
   input  logic [8*N_REQ-1:0]   i_req_addr,
   input  logic [8*N_REQ-1:0]   i_req_wdata,
   output logic [N_REQ-1:0]     o_req_ready,
   output logic [N_REQ-1:0]     o_rsp_valid,
   output logic [7:0]           o_rsp_data,
   output logic                 o_rsp_err,
   output logic [1:0]           o_opcode,
   output logic [7:0]           o_reg_addr,
   output logic [7:0]           o_tx_data,
   input  logic [7:0]           i_reg_data,
   input  logic                 i_done,
   output logic                 o_busy,
   output logic [2:0]           o_grant_id
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_GAP
   } state_t;

   state_t            state, state_nx;
   logic [2:0]        ptr, ptr_nx;
   logic [2:0]        grant_nx;
   logic [1:0]        op_q, op_nx;
   logic [TW-1:0]     tmr, tmr_nx;
   logic [GW-1:0]     gap_cnt, gap_nx;
   logic [N_REQ-1:0]  ready_nx, rspv_nx;
   logic [7:0]        rspd_nx, addr_nx, txd_nx;
   logic              rspe_nx;
   logic [1:0]        opcode_nx;

   // Request buses padded to the 8-requester maximum so a 3-bit index always fits.
   logic [7:0]        valid_pad;
   logic [15:0]       op_pad;
   logic [63:0]       addr_pad, wdata_pad;
   logic [3:0]        cand;
   logic              sel_found;
   logic [2:0]        sel_idx;
   logic [1:0]        sel_op;
   logic [7:0]        sel_addr, sel_wdata;
   logic [N_REQ-1:0]  sel_vec, own_vec;

   assign valid_pad = 8'(i_req_valid);
   assign op_pad    = 16'(i_req_opcode);
   assign addr_pad  = 64'(i_req_addr);
   assign wdata_pad = 64'(i_req_wdata);

   // Round-robin search: first pending requester starting just after the last owner.
   always_comb begin
      cand      = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = {1'b0, ptr} + 4'(i);
         if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
         if (!sel_found && valid_pad[cand[2:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[2:0];
         end
      end
      sel_op    = op_pad[{sel_idx, 1'b0} +: 2];
      sel_addr  = addr_pad[{sel_idx, 3'b000} +: 8];
      sel_wdata = wdata_pad[{sel_idx, 3'b000} +: 8];
      for (int k = 0; k < N_REQ; k++) begin
         sel_vec[k] = (3'(k) == sel_idx);
         own_vec[k] = (3'(k) == o_grant_id);
      end
   end

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      grant_nx  = o_grant_id;
      op_nx     = op_q;
      tmr_nx    = tmr;
      gap_nx    = gap_cnt;
      ready_nx  = '0;
      rspv_nx   = '0;
      rspd_nx   = o_rsp_data;
      rspe_nx   = o_rsp_err;
      opcode_nx = 2'd0;
      addr_nx   = o_reg_addr;
      txd_nx    = o_tx_data;
      unique case (state)
         S_IDLE: begin
            if (sel_found) begin
               ptr_nx   = sel_idx;
               grant_nx = sel_idx;
               op_nx    = sel_op;
               addr_nx  = sel_addr;
               txd_nx   = sel_wdata;
               ready_nx = sel_vec;
               if (sel_op == OP_READ || sel_op == OP_WRITE) begin
                  state_nx  = S_ISSUE;
                  opcode_nx = sel_op;
               end else begin
                  // Illegal opcode never reaches the engine; answer immediately.
                  state_nx = S_RESP;
                  rspv_nx  = sel_vec;
                  rspd_nx  = 8'h00;
                  rspe_nx  = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            state_nx = S_WAIT;
            tmr_nx   = TW'(1);
         end
         S_WAIT: begin
            if (i_done) begin
               state_nx = S_RESP;
               rspv_nx  = own_vec;
               rspd_nx  = (op_q == OP_WRITE) ? 8'h00 : i_reg_data;
               rspe_nx  = 1'b0;
            end else if (tmr >= TW'(TIMEOUT_CYCLES - 1)) begin
               state_nx = S_RESP;
               rspv_nx  = own_vec;
               rspd_nx  = 8'h00;
               rspe_nx  = 1'b1;
            end else begin
               tmr_nx = tmr + TW'(1);
            end
         end
         S_RESP: begin
            gap_nx   = '0;
            state_nx = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nx = S_IDLE;
            else gap_nx = gap_cnt + GW'(1);
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any op without issuing a response.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         ptr         <= 3'(N_REQ - 1);
         op_q        <= 2'd0;
         tmr         <= '0;
         gap_cnt     <= '0;
         o_req_ready <= '0;
         o_rsp_valid <= '0;
         o_rsp_data  <= 8'h00;
         o_rsp_err   <= 1'b0;
         o_opcode    <= 2'd0;
         o_reg_addr  <= 8'h00;
         o_tx_data   <= 8'h00;
         o_busy      <= 1'b0;
         o_grant_id  <= 3'd0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         op_q        <= op_nx;
         tmr         <= tmr_nx;
         gap_cnt     <= gap_nx;
         o_req_ready <= ready_nx;
         o_rsp_valid <= rspv_nx;
         o_rsp_data  <= rspd_nx;
         o_rsp_err   <= rspe_nx;
         o_opcode    <= opcode_nx;
         o_reg_addr  <= addr_nx;
         o_tx_data   <= txd_nx;
         o_busy      <= (state_nx != S_IDLE);
         o_grant_id  <= grant_nx;
      end
   end

endmodule

// File: tb/tb_bno055_op_arbiter.sv
// Directed bench for bno055_op_arbiter: expected responses are queued when an engine
// outcome is decided and compared by a monitor when o_rsp_valid pulses.
module tb_bno055_op_arbiter;

   localparam int N = 3;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [2*N-1:0]   req_opcode;
   logic [8*N-1:0]   req_addr;
   logic [8*N-1:0]   req_wdata;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     rsp_valid;
   logic [7:0]       rsp_data;
   logic             rsp_err;
   logic [1:0]       opcode;
   logic [7:0]       reg_addr;
   logic [7:0]       tx_data;
   logic [7:0]       reg_data;
   logic             done;
   logic             busy;
   logic [2:0]       grant_id;

   typedef struct packed {
      logic [2:0] id;
      logic [7:0] data;
      logic       err;
   } rsp_t;

   rsp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc;
   int   last;
   int   expId;

   bno055_op_arbiter #(
      .N_REQ(N),
      .TIMEOUT_CYCLES(100),
      .GAP_CYCLES(4)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_req_valid(req_valid),
      .i_req_opcode(req_opcode),
      .i_req_addr(req_addr),
      .i_req_wdata(req_wdata),
      .o_req_ready(req_ready),
      .o_rsp_valid(rsp_valid),
      .o_rsp_data(rsp_data),
      .o_rsp_err(rsp_err),
      .o_opcode(opcode),
      .o_reg_addr(reg_addr),
      .o_tx_data(tx_data),
      .i_reg_data(reg_data),
      .i_done(done),
      .o_busy(busy),
      .o_grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int k, input logic v, input logic [1:0] op,
                                input logic [7:0] addr, input logic [7:0] wdata);
      req_valid[k]          = v;
      req_opcode[2*k +: 2]  = op;
      req_addr[8*k +: 8]    = addr;
      req_wdata[8*k +: 8]   = wdata;
   endtask

   task automatic waitReady(output int n);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (req_ready == '0 && n < 40);
   endtask

   task automatic pushExp(input int id, input logic [7:0] data, input logic err);
      rsp_t e;
      e.id   = 3'(id);
      e.data = data;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   // Response monitor: every o_rsp_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      rsp_t e;
      if (rst_n && rsp_valid != '0) begin
         if (exp_q.size() == 0) begin
            checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("rsp_owner", 32'(rsp_valid), 32'd1 << e.id);
            checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
            checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      req_opcode = '0;
      req_addr   = '0;
      req_wdata  = '0;
      reg_data   = 8'h00;
      done       = 1'b0;

      #3;
      checkOutput("reset_outputs", {reg_addr, tx_data, rsp_data, 4'(opcode), 4'(grant_id),
                                    1'b0, busy, rsp_err, 1'b0, 1'(0)} , 32'd0);
      checkOutput("reset_handshake", 32'({req_ready, rsp_valid}), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Single READ from requester 0, engine answers 40 cycles after the opcode.
      applyStimulus(0, 1'b1, 2'd1, 8'h1C, 8'h00);
      waitReady(cyc);
      checkOutput("rd_latency", 32'(cyc), 32'd1);
      checkOutput("rd_ready", 32'(req_ready), 32'b001);
      checkOutput("rd_opcode", 32'(opcode), 32'd1);
      checkOutput("rd_addr", 32'(reg_addr), 32'h1C);
      checkOutput("rd_grant", 32'(grant_id), 32'd0);
      checkOutput("rd_busy", 32'(busy), 32'd1);
      applyStimulus(0, 1'b0, 2'd1, 8'h1C, 8'h00);
      tick(1);
      checkOutput("rd_opcode_pulse", 32'(opcode), 32'd0);
      checkOutput("rd_ready_pulse", 32'(req_ready), 32'd0);
      tick(39);
      pushExp(0, 8'h5A, 1'b0);
      done = 1'b1;
      reg_data = 8'h5A;
      tick(1);
      done = 1'b0;
      checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'b001);
      tick(5);
      checkOutput("rd_idle_after_gap", 32'(busy), 32'd0);
      last = 0;

      // Round-robin with every requester continuously pending.
      applyStimulus(0, 1'b1, 2'd1, 8'h10, 8'h00);
      applyStimulus(1, 1'b1, 2'd1, 8'h11, 8'h00);
      applyStimulus(2, 1'b1, 2'd1, 8'h12, 8'h00);
      for (int n = 0; n < 6; n++) begin
         expId = (last + 1) % N;
         waitReady(cyc);
         checkOutput("rr_ready", 32'(req_ready), 32'd1 << expId);
         checkOutput("rr_grant", 32'(grant_id), 32'(expId));
         checkOutput("rr_addr", 32'(reg_addr), 32'h10 + 32'(expId));
         last = expId;
         tick(1);
         checkOutput("rr_single_opcode", 32'(opcode), 32'd0);
         tick(2);
         pushExp(expId, 8'hA0 + 8'(n), 1'b0);
         done = 1'b1;
         reg_data = 8'hA0 + 8'(n);
         tick(1);
         done = 1'b0;
      end
      req_valid = '0;
      tick(5);

      // Timeout: engine never completes.
      applyStimulus(1, 1'b1, 2'd1, 8'h28, 8'h00);
      waitReady(cyc);
      checkOutput("to_grant", 32'(grant_id), 32'd1);
      last = 1;
      applyStimulus(1, 1'b0, 2'd1, 8'h28, 8'h00);
      pushExp(1, 8'h00, 1'b1);
      tick(99);
      checkOutput("to_not_early", 32'(rsp_valid), 32'd0);
      tick(1);
      checkOutput("to_rsp_valid", 32'(rsp_valid), 32'b010);
      tick(1);
      done = 1'b1;
      reg_data = 8'hEE;
      tick(1);
      done = 1'b0;
      checkOutput("late_done_ignored", 32'(rsp_valid), 32'd0);
      tick(3);
      checkOutput("to_idle", 32'(busy), 32'd0);

      // WRITE: write data on the bus, response data forced to zero.
      applyStimulus(2, 1'b1, 2'd2, 8'h3D, 8'h0C);
      waitReady(cyc);
      checkOutput("wr_ready", 32'(req_ready), 32'b100);
      checkOutput("wr_opcode", 32'(opcode), 32'd2);
      checkOutput("wr_txdata", 32'(tx_data), 32'h0C);
      last = 2;
      applyStimulus(2, 1'b0, 2'd2, 8'h3D, 8'h0C);
      tick(2);
      pushExp(2, 8'h00, 1'b0);
      done = 1'b1;
      reg_data = 8'hFF;
      tick(1);
      done = 1'b0;
      tick(5);

      // Illegal opcodes 0 and 3: ready and response in the same cycle, no engine op.
      applyStimulus(1, 1'b1, 2'd0, 8'h55, 8'h00);
      pushExp(1, 8'h00, 1'b1);
      waitReady(cyc);
      checkOutput("ill0_latency", 32'(cyc), 32'd1);
      checkOutput("ill0_ready", 32'(req_ready), 32'b010);
      checkOutput("ill0_rsp", 32'(rsp_valid), 32'b010);
      checkOutput("ill0_opcode", 32'(opcode), 32'd0);
      applyStimulus(1, 1'b0, 2'd0, 8'h55, 8'h00);
      tick(1);
      checkOutput("ill0_opcode_after", 32'(opcode), 32'd0);
      tick(4);
      checkOutput("ill0_idle", 32'(busy), 32'd0);
      applyStimulus(0, 1'b1, 2'd3, 8'h56, 8'h00);
      pushExp(0, 8'h00, 1'b1);
      waitReady(cyc);
      checkOutput("ill3_ready", 32'(req_ready), 32'b001);
      checkOutput("ill3_opcode", 32'(opcode), 32'd0);
      applyStimulus(0, 1'b0, 2'd3, 8'h56, 8'h00);
      tick(5);

      // Done arrives on the very cycle the timeout would expire: done wins.
      applyStimulus(0, 1'b1, 2'd1, 8'h1A, 8'h00);
      waitReady(cyc);
      checkOutput("col_grant", 32'(grant_id), 32'd0);
      applyStimulus(0, 1'b0, 2'd1, 8'h1A, 8'h00);
      tick(99);
      checkOutput("col_not_early", 32'(rsp_valid), 32'd0);
      pushExp(0, 8'h77, 1'b0);
      done = 1'b1;
      reg_data = 8'h77;
      tick(1);
      done = 1'b0;
      checkOutput("col_rsp_valid", 32'(rsp_valid), 32'b001);
      checkOutput("col_err", 32'(rsp_err), 32'd0);
      tick(5);

      // Reset while waiting on the engine, then requester 0 must win first.
      applyStimulus(1, 1'b1, 2'd1, 8'h08, 8'h00);
      waitReady(cyc);
      checkOutput("rst_pre_grant", 32'(grant_id), 32'd1);
      applyStimulus(1, 1'b0, 2'd1, 8'h08, 8'h00);
      tick(3);
      checkOutput("rst_pre_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_zero", {reg_addr, tx_data, rsp_data, 3'd0, busy,
                                     1'b0, grant_id, opcode, rsp_err, 1'b0}, 32'd0);
      checkOutput("rst_async_handshake", 32'({req_ready, rsp_valid}), 32'd0);
      applyStimulus(0, 1'b1, 2'd1, 8'h20, 8'h00);
      applyStimulus(1, 1'b1, 2'd1, 8'h21, 8'h00);
      tick(2);
      rst_n = 1'b1;
      waitReady(cyc);
      checkOutput("rst_first_ready", 32'(req_ready), 32'b001);
      checkOutput("rst_first_grant", 32'(grant_id), 32'd0);
      applyStimulus(0, 1'b0, 2'd1, 8'h20, 8'h00);
      tick(2);
      pushExp(0, 8'h31, 1'b0);
      done = 1'b1;
      reg_data = 8'h31;
      tick(1);
      done = 1'b0;
      waitReady(cyc);
      checkOutput("rst_second_ready", 32'(req_ready), 32'b010);
      checkOutput("rst_second_addr", 32'(reg_addr), 32'h21);
      applyStimulus(1, 1'b0, 2'd1, 8'h21, 8'h00);
      tick(2);
      pushExp(1, 8'h32, 1'b0);
      done = 1'b1;
      reg_data = 8'h32;
      tick(1);
      done = 1'b0;
      tick(6);

      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
